// File: rtl/pellet_pkg.sv
// pellet_pkg: maze geometry, cell/state types and the shipped pellet map.
// Shared by pellet_tracker and pellet_init_rom.
package pellet_pkg;

  localparam int COLS  = 28;
  localparam int ROWS  = 31;
  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);

  typedef enum logic [1:0] {
    PEL_NONE  = 2'b00,
    PEL_SMALL = 2'b01,
    PEL_POWER = 2'b10
  } pellet_t;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_CHECK = 2'd2
  } tracker_state_t;

  // Shipped map: nine corridor rows (gap at columns 13/14)
  // plus five rows with pellets only on the outer walls.
  // 9*26 + 5*2 = 244 pellets, four of them power.
  function automatic pellet_t map_cell(
    input int x,
    input int y
  );
    logic full;
    logic side;
    logic edge_x;
    pellet_t c;
    full = (y == 0) || (y == 2) || (y == 6) ||
           (y == 10) || (y == 14) || (y == 18) ||
           (y == 22) || (y == 26) || (y == 30);
    side = (y == 1) || (y == 3) || (y == 4) ||
           (y == 5) || (y == 7);
    edge_x = (x == 0) || (x == COLS - 1);
    c = PEL_NONE;
    if (full && x >= 0 && x < COLS &&
        x != 13 && x != 14) begin
      if (edge_x && (y == 2 || y == 22))
        c = PEL_POWER;
      else
        c = PEL_SMALL;
    end else if (side && edge_x) begin
      c = PEL_SMALL;
    end
    return c;
  endfunction

  function automatic pellet_t rom_cell(
    input logic [AW-1:0] a
  );
    int ai;
    ai = int'(a);
    return map_cell(ai % COLS, ai / COLS);
  endfunction

  function automatic logic [AW-1:0] cell_addr(
    input logic [4:0] x,
    input logic [4:0] y
  );
    return AW'(y) * AW'(COLS) + AW'(x);
  endfunction

  function automatic logic in_range(
    input logic [4:0] x,
    input logic [4:0] y
  );
    return (x < 5'(COLS)) && (y < 5'(ROWS));
  endfunction

endpackage

// File: rtl/pellet_tracker_init_rom.sv
// pellet_init_rom: synchronous 868x2 initial-map ROM, 1-cycle latency.
// Ports: clk, rst (async active-low), addr in, data out.
module pellet_init_rom
  import pellet_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  output pellet_t       data
);

  pellet_t data_q;
  pellet_t data_d;

  always_comb begin
    data_d = rom_cell(addr);
  end

  // Reset preloads cell 0 so the first load cycle
  // after reset release already has its data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) data_q <= rom_cell('0);
    else      data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/pellet_tracker.sv
// pellet_tracker: live pellet map, eat detection, remaining count.
// Ports: clk, rst (async active-low), level_restart, pac_* write
// side, rd_* renderer side, eat_small/eat_power, remaining,
// board_clear, busy, frightened. Option: PELLET_FRIGHT_TIMER_EN.
module pellet_tracker
  import pellet_pkg::*;
#(
  parameter logic [23:0] FRIGHT_CYCLES = 24'd6_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       level_restart,
  input  logic       pac_valid,
  output logic       pac_ready,
  input  logic [4:0] pac_xtile,
  input  logic [4:0] pac_ytile,
  input  logic [4:0] rd_xtile,
  input  logic [4:0] rd_ytile,
  output logic [1:0] rd_pellet,
  output logic       eat_small,
  output logic       eat_power,
  output logic [9:0] remaining,
  output logic       board_clear,
  output logic       busy,
  output logic       frightened
);

  tracker_state_t state_q, state_d;
  logic [AW-1:0]  load_addr_q, load_addr_d;
  logic [AW-1:0]  chk_addr_q, chk_addr_d;
  logic [9:0]     remaining_q, remaining_d;
  logic           eat_small_q, eat_small_d;
  logic           eat_power_q, eat_power_d;
  logic           board_clear_q, board_clear_d;
  pellet_t        rd_pellet_q, rd_pellet_d;
  pellet_t        portb_q, portb_d;

  pellet_t        rom_data;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  pellet_t        wr_data;

  logic [AW-1:0]  rd_addr;
  logic [AW-1:0]  pac_addr;
  logic           rd_ok;
  logic           pac_ok;

  pellet_t        mem [CELLS];

  assign rd_addr  = cell_addr(rd_xtile, rd_ytile);
  assign pac_addr = cell_addr(pac_xtile, pac_ytile);
  assign rd_ok    = in_range(rd_xtile, rd_ytile) &&
                    (state_q != ST_INIT);
  assign pac_ok   = in_range(pac_xtile, pac_ytile);

  // ROM runs one address ahead of the write pointer.
  pellet_init_rom u_rom (
    .clk  (clk),
    .rst  (rst),
    .addr (load_addr_d),
    .data (rom_data)
  );

  // Both ports sample the array before this edge's write
  // lands, so a same-cell collision returns the old value.
  always_comb begin
    rd_pellet_d = rd_ok ? mem[rd_addr] : PEL_NONE;
    portb_d     = pac_ok ? mem[pac_addr] : PEL_NONE;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    state_d     = state_q;
    load_addr_d = load_addr_q;
    chk_addr_d  = chk_addr_q;
    remaining_d = remaining_q;
    eat_small_d = 1'b0;
    eat_power_d = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = load_addr_q;
    wr_data     = rom_data;
    if (level_restart) begin
      state_d     = ST_INIT;
      load_addr_d = '0;
      remaining_d = '0;
    end else begin
      unique case (state_q)
        ST_INIT: begin
          wr_en = 1'b1;
          if (rom_data != PEL_NONE)
            remaining_d = remaining_q + 10'd1;
          if (load_addr_q == AW'(CELLS - 1)) begin
            state_d     = ST_IDLE;
            load_addr_d = '0;
          end else begin
            load_addr_d = load_addr_q + AW'(1);
          end
        end
        ST_IDLE: begin
          if (pac_valid && pac_ok) begin
            state_d    = ST_CHECK;
            chk_addr_d = pac_addr;
          end
        end
        ST_CHECK: begin
          state_d = ST_IDLE;
          if (portb_q != PEL_NONE) begin
            wr_en       = 1'b1;
            wr_addr     = chk_addr_q;
            wr_data     = PEL_NONE;
            eat_small_d = (portb_q == PEL_SMALL);
            eat_power_d = (portb_q == PEL_POWER);
            if (remaining_q != 10'd0)
              remaining_d = remaining_q - 10'd1;
          end
        end
        default: begin
          state_d     = ST_INIT;
          load_addr_d = '0;
          remaining_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    if (state_d == ST_INIT)
      board_clear_d = 1'b0;
    else
      board_clear_d = board_clear_q ||
                      (remaining_d == 10'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_INIT;
      load_addr_q   <= '0;
      chk_addr_q    <= '0;
      remaining_q   <= '0;
      eat_small_q   <= 1'b0;
      eat_power_q   <= 1'b0;
      board_clear_q <= 1'b0;
      rd_pellet_q   <= PEL_NONE;
      portb_q       <= PEL_NONE;
    end else begin
      state_q       <= state_d;
      load_addr_q   <= load_addr_d;
      chk_addr_q    <= chk_addr_d;
      remaining_q   <= remaining_d;
      eat_small_q   <= eat_small_d;
      eat_power_q   <= eat_power_d;
      board_clear_q <= board_clear_d;
      rd_pellet_q   <= rd_pellet_d;
      portb_q       <= portb_d;
    end
  end

`ifdef PELLET_FRIGHT_TIMER_EN
  logic [23:0] fright_q, fright_d;

  // A second power pellet restarts the full duration.
  always_comb begin
    if (level_restart)
      fright_d = '0;
    else if (eat_power_d)
      fright_d = FRIGHT_CYCLES;
    else if (fright_q != '0)
      fright_d = fright_q - 24'd1;
    else
      fright_d = fright_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fright_q <= '0;
    else      fright_q <= fright_d;
  end

  assign frightened = (fright_q != '0);
`else
  logic unused_fright;
  assign unused_fright = ^FRIGHT_CYCLES;
  assign frightened    = 1'b0;
`endif

  assign pac_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q == ST_INIT);
  assign rd_pellet   = rd_pellet_q;
  assign eat_small   = eat_small_q;
  assign eat_power   = eat_power_q;
  assign remaining   = remaining_q;
  assign board_clear = board_clear_q;

endmodule

// File: tb/tb_pellet_tracker.sv
// tb_pellet_tracker: directed self-checking bench for pellet_tracker.
// Keeps its own shadow map of the shipped maze.
module tb_pellet_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       level_restart = 1'b0;
  logic       pac_valid = 1'b0;
  logic [4:0] pac_xtile = '0;
  logic [4:0] pac_ytile = '0;
  logic [4:0] rd_xtile = '0;
  logic [4:0] rd_ytile = '0;
  logic       pac_ready;
  logic [1:0] rd_pellet;
  logic       eat_small;
  logic       eat_power;
  logic [9:0] remaining;
  logic       board_clear;
  logic       busy;
  logic       frightened;

  pellet_tracker dut (
    .clk           (clk),
    .rst           (rst),
    .level_restart (level_restart),
    .pac_valid     (pac_valid),
    .pac_ready     (pac_ready),
    .pac_xtile     (pac_xtile),
    .pac_ytile     (pac_ytile),
    .rd_xtile      (rd_xtile),
    .rd_ytile      (rd_ytile),
    .rd_pellet     (rd_pellet),
    .eat_small     (eat_small),
    .eat_power     (eat_power),
    .remaining     (remaining),
    .board_clear   (board_clear),
    .busy          (busy),
    .frightened    (frightened)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [1:0] mdl [868];
  int         rem_m;
  logic       bc_m;
  int         n;
`ifdef PELLET_FRIGHT_TIMER_EN
  logic       fr_exp = 1'b1;
`else
  logic       fr_exp = 1'b0;
`endif

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Row kinds: F = corridor (gap at x 13/14),
  // S = outer walls only, . = empty.
  function automatic logic [1:0] ref_cell(input int x,
                                          input int y);
    string kind;
    logic [1:0] c;
    kind = "FSFSSSFS..F...F...F...F...F...F";
    c = 2'b00;
    if (kind[y] == "F" && x != 13 && x != 14) c = 2'b01;
    if (kind[y] == "S" && (x == 0 || x == 27)) c = 2'b01;
    if ((x == 0 || x == 27) && (y == 2 || y == 22))
      c = 2'b10;
    return c;
  endfunction

  task automatic load_model();
    for (int y = 0; y < 31; y++)
      for (int x = 0; x < 28; x++)
        mdl[y*28+x] = ref_cell(x, y);
    rem_m = 244;
    bc_m  = 1'b0;
  endtask

  task automatic rd(input int x, input int y,
                    input logic [1:0] exp);
    rd_xtile = 5'(x);
    rd_ytile = 5'(y);
    tick();
    chk($sformatf("rd(%0d,%0d)", x, y), 32'(rd_pellet), 32'(exp));
  endtask

  task automatic eat(input int x, input int y);
    logic inr;
    logic [1:0] e;
    inr = (x < 28) && (y < 31);
    e = inr ? mdl[y*28+x] : 2'b00;
    pac_xtile = 5'(x);
    pac_ytile = 5'(y);
    pac_valid = 1'b1;
    tick();
    pac_valid = 1'b0;
    chk($sformatf("ready_t1(%0d,%0d)", x, y),
        32'(pac_ready), 32'(!inr));
    chk($sformatf("no_early(%0d,%0d)", x, y),
        32'({eat_small, eat_power}), 32'd0);
    tick();
    if (e != 2'b00) begin
      mdl[y*28+x] = 2'b00;
      if (rem_m > 0) rem_m--;
    end
    if (rem_m == 0) bc_m = 1'b1;
    chk($sformatf("eat_small(%0d,%0d)", x, y),
        32'(eat_small), 32'(e == 2'b01));
    chk($sformatf("eat_power(%0d,%0d)", x, y),
        32'(eat_power), 32'(e == 2'b10));
    chk($sformatf("remaining(%0d,%0d)", x, y),
        32'(remaining), 32'(rem_m));
    chk($sformatf("board_clear(%0d,%0d)", x, y),
        32'(board_clear), 32'(bc_m));
    chk($sformatf("ready_t2(%0d,%0d)", x, y),
        32'(pac_ready), 32'd1);
  endtask

  task automatic wait_load(input string tag);
    n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    chk(tag, 32'(n), 32'd868);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_ready"}, 32'(pac_ready), 32'd0);
    chk({tag, "_rem"}, 32'(remaining), 32'd0);
    chk({tag, "_rd"}, 32'(rd_pellet), 32'd0);
    chk({tag, "_eat"}, 32'({eat_small, eat_power}), 32'd0);
    chk({tag, "_bc"}, 32'(board_clear), 32'd0);
    chk({tag, "_fr"}, 32'(frightened), 32'd0);
  endtask

  initial begin
    load_model();
    repeat (3) tick();
    chk_reset_vals("reset");

    // 1: initial load
    rst = 1'b1;
    wait_load("init_cycles");
    chk("init_remaining", 32'(remaining), 32'd244);
    chk("init_bc", 32'(board_clear), 32'd0);
    chk("init_ready", 32'(pac_ready), 32'd1);
    rd(0, 0, 2'b01);
    rd(0, 2, 2'b10);
    rd(13, 0, 2'b00);
    rd(27, 22, 2'b10);
    rd(28, 0, 2'b00);
    rd(0, 31, 2'b00);

    // 2: small pellet, then pulse gone and cell empty
    eat(1, 0);
    tick();
    chk("small_t3", 32'(eat_small), 32'd0);
    rd(1, 0, 2'b00);
    eat(1, 0);

    // 3: power pellets
    eat(27, 22);
    chk("fright_1", 32'(frightened), 32'(fr_exp));
    eat(0, 22);
    chk("fright_2", 32'(frightened), 32'(fr_exp));

    // 4: out-of-range requests
    eat(28, 5);
    eat(3, 31);

    // 5: restart during CHECK
    eat(2, 0);
    eat(3, 0);
    eat(4, 0);
    eat(5, 0);
    eat(0, 1);
    pac_xtile = 5'd6;
    pac_ytile = 5'd0;
    pac_valid = 1'b1;
    tick();
    pac_valid = 1'b0;
    chk("rst_chk_ready", 32'(pac_ready), 32'd0);
    level_restart = 1'b1;
    tick();
    level_restart = 1'b0;
    chk("rst_chk_pulse", 32'({eat_small, eat_power}), 32'd0);
    chk("rst_chk_busy", 32'(busy), 32'd1);
    chk("rst_chk_rem", 32'(remaining), 32'd0);
    chk("rst_chk_fr", 32'(frightened), 32'd0);
    rd_xtile = 5'd0;
    rd_ytile = 5'd0;
    tick();
    chk("rd_while_busy", 32'(rd_pellet), 32'd0);
    n = 1;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    chk("reload_cycles", 32'(n), 32'd868);
    load_model();
    chk("reload_rem", 32'(remaining), 32'd244);
    rd(1, 0, 2'b01);
    rd(6, 0, 2'b01);
    rd(0, 1, 2'b01);
    rd(27, 22, 2'b10);

    // 6: clear the board
    for (int y = 0; y < 31; y++)
      for (int x = 0; x < 28; x++)
        if (mdl[y*28+x] != 2'b00) eat(x, y);
    chk("clear_rem", 32'(remaining), 32'd0);
    chk("clear_bc", 32'(board_clear), 32'd1);
    eat(0, 0);

    // reload, eat a power pellet, collision read, async reset
    level_restart = 1'b1;
    tick();
    level_restart = 1'b0;
    chk("bc_cleared", 32'(board_clear), 32'd0);
    wait_load("final_load");
    load_model();
    rd_xtile = 5'd0;
    rd_ytile = 5'd2;
    pac_xtile = 5'd0;
    pac_ytile = 5'd2;
    pac_valid = 1'b1;
    tick();
    pac_valid = 1'b0;
    tick();
    chk("last_power", 32'(eat_power), 32'd1);
    chk("last_rem", 32'(remaining), 32'd243);
    chk("rd_collision_old", 32'(rd_pellet), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_vals("midrun");
    tick();
    rst = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
